vcxo_lock_monitor: RTL and testbench

VCXO_LOCK_MONITOR -- requirements
Module: vcxo_lock_monitor

---
 rtl/vcxo_lock_monitor.sv | 182 ++++++++++++++++++
 tb/tb_vcxo_lock_monitor.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcxo_lock_monitor.sv
// VCXO lock monitor: averages the last 8 frequency-error samples and runs a
// lock FSM with acquire/hold hysteresis and a stale-measurement timeout.
module vcxo_lock_monitor #(
  parameter int LOCK_THR       = 20,
  parameter int UNLOCK_THR     = 50,
  parameter int LOCK_COUNT     = 8,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic        tcxo_clk_in,
  input  logic        reset_in,
  input  logic [23:0] freq_error,
  input  logic        freq_error_valid,
  output logic [23:0] avg_error,
  output logic [1:0]  lock_state,
  output logic        vcxo_locked,
  output logic        lock_lost,
  output logic [15:0] sample_count
);

  localparam int DATA_W = 24;
  localparam int SUM_W  = 27;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DATA_W-1:0] LOCK_THR_U   = DATA_W'(LOCK_THR);
  localparam logic [DATA_W-1:0] UNLOCK_THR_U = DATA_W'(UNLOCK_THR);
  localparam logic [7:0]        LOCK_CNT_U   = 8'(LOCK_COUNT);
  localparam logic [IDLE_W-1:0] IDLE_MAX     = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_HIT     = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_ACQUIRING = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_STALE     = 2'd3
  } state_t;

  // The most negative input has no positive twin, so it clips to full scale.
  function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
    if (x == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
    else if (x < 0)                       return $unsigned(-x);
    else                                  return $unsigned(x);
  endfunction

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    return {{(SUM_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

  // Floor division by 8; the 27-bit sum of 8 samples always fits back in 24 bits.
  function automatic logic signed [DATA_W-1:0] mean8(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sh = s >>> 3;
    return sh[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] ring_q [8];
  logic signed [DATA_W-1:0] ring_d [8];
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [2:0]               wr_ptr_q, wr_ptr_d;
  logic [3:0]               fill_q, fill_d;
  logic [7:0]               good_cnt_q, good_cnt_d;
  logic [IDLE_W-1:0]        idle_q, idle_d;
  logic [15:0]              sample_count_q, sample_count_d;
  logic signed [DATA_W-1:0] avg_q, avg_d;
  state_t                   state_q, state_d;
  logic                     locked_q, locked_d;
  logic                     lost_q, lost_d;

  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] oldest;
  logic [DATA_W-1:0]        err_abs;
  logic [DATA_W-1:0]        avg_abs;
  logic [7:0]               cnt_inc;
  logic                     timeout_hit;

  assign sample      = $signed(freq_error);
  assign oldest      = ring_q[wr_ptr_q];
  assign err_abs     = abs_sat(sample);
  assign cnt_inc     = (good_cnt_q >= LOCK_CNT_U) ? LOCK_CNT_U : good_cnt_q + 8'd1;
  assign timeout_hit = (idle_q == IDLE_HIT);

  always_comb begin
    ring_d         = ring_q;
    sum_d          = sum_q;
    wr_ptr_d       = wr_ptr_q;
    fill_d         = fill_q;
    good_cnt_d     = good_cnt_q;
    idle_d         = idle_q;
    sample_count_d = sample_count_q;
    avg_d          = avg_q;
    state_d        = state_q;
    lost_d         = 1'b0;
    avg_abs        = '0;

    if (freq_error_valid) begin
      ring_d[wr_ptr_q] = sample;
      wr_ptr_d         = wr_ptr_q + 3'd1;
      sum_d            = sum_q + sext(sample) - sext(oldest);
      fill_d           = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
      avg_d            = mean8(sum_d);
      avg_abs          = abs_sat(avg_d);
      sample_count_d   = sample_count_q + 16'd1;
      idle_d           = '0;

      case (state_q)
        ST_UNLOCKED: begin
          if (err_abs <= LOCK_THR_U) begin
            state_d    = ST_ACQUIRING;
            good_cnt_d = 8'd1;
          end else begin
            good_cnt_d = 8'd0;
          end
        end
        ST_ACQUIRING: begin
          if (err_abs > LOCK_THR_U) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = 8'd0;
          end else begin
            good_cnt_d = cnt_inc;
            if (cnt_inc >= LOCK_CNT_U && fill_d == 4'd8 && avg_abs <= LOCK_THR_U)
              state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (err_abs > UNLOCK_THR_U) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = 8'd0;
            lost_d     = 1'b1;
          end
        end
        default: begin
          // First sample after a stale period only re-arms the FSM.
          state_d    = ST_UNLOCKED;
          good_cnt_d = 8'd0;
        end
      endcase
    end else begin
      if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
      if (timeout_hit && (state_q == ST_ACQUIRING || state_q == ST_LOCKED)) begin
        state_d    = ST_STALE;
        good_cnt_d = 8'd0;
        lost_d     = (state_q == ST_LOCKED);
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge tcxo_clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < 8; i++) ring_q[i] <= '0;
      sum_q          <= '0;
      wr_ptr_q       <= '0;
      fill_q         <= '0;
      good_cnt_q     <= '0;
      idle_q         <= '0;
      sample_count_q <= '0;
      avg_q          <= '0;
      state_q        <= ST_UNLOCKED;
      locked_q       <= 1'b0;
      lost_q         <= 1'b0;
    end else begin
      ring_q         <= ring_d;
      sum_q          <= sum_d;
      wr_ptr_q       <= wr_ptr_d;
      fill_q         <= fill_d;
      good_cnt_q     <= good_cnt_d;
      idle_q         <= idle_d;
      sample_count_q <= sample_count_d;
      avg_q          <= avg_d;
      state_q        <= state_d;
      locked_q       <= locked_d;
      lost_q         <= lost_d;
    end
  end

  assign avg_error    = avg_q;
  assign lock_state   = state_q;
  assign vcxo_locked  = locked_q;
  assign lock_lost    = lost_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_vcxo_lock_monitor.sv
// Scoreboard bench for vcxo_lock_monitor: each strobe pushes its expected
// outputs, which are popped and compared one cycle later.
module tb_vcxo_lock_monitor;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] fe  = '0;
  logic        fev = 1'b0;
  logic [23:0] avg;
  logic [1:0]  st;
  logic        locked;
  logic        lost;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  st;
    logic        lost;
    logic [23:0] avg;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          hist[$];
  logic [15:0] exp_cnt = '0;

  vcxo_lock_monitor #(
    .LOCK_THR(20), .UNLOCK_THR(50), .LOCK_COUNT(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .tcxo_clk_in(clk),
    .reset_in(rst),
    .freq_error(fe),
    .freq_error_valid(fev),
    .avg_error(avg),
    .lock_state(st),
    .vcxo_locked(locked),
    .lock_lost(lost),
    .sample_count(cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=2000000", $time);
    $fatal(1);
  end

  task automatic model_clear();
    hist.delete();
    sbq.delete();
    exp_cnt = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Drive one strobe after gap idle cycles and queue what the outputs should be.
  task automatic send(input int gap, input int v, input logic [1:0] exp_st, input logic exp_lost);
    exp_t   e;
    longint s;
    longint q;
    repeat (gap) @(negedge clk);
    fe  = 24'(v);
    fev = 1'b1;
    hist.push_back(v);
    if (hist.size() > 8) void'(hist.pop_front());
    s = 0;
    foreach (hist[i]) s += hist[i];
    q = s / 8;
    if (s < 0 && (s % 8) != 0) q = q - 1;
    exp_cnt  = exp_cnt + 16'd1;
    e.st     = exp_st;
    e.lost   = exp_lost;
    e.avg    = 24'(q);
    e.cnt    = exp_cnt;
    sbq.push_back(e);
    @(negedge clk);
    fev = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fev = 1'b1;
    fe  = 24'd7;
    repeat (3) @(negedge clk);
    checks++;
    if ({st, locked, lost, avg, cnt} !== 44'd0) begin
      errors++;
      $display("FAIL reset_hold: st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want all 0",
               st, locked, lost, $signed(avg), cnt);
    end
    fev = 1'b0;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if ({st, locked, lost, avg, cnt} !== 44'd0) begin
      errors++;
      $display("FAIL reset_release: st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want all 0",
               st, locked, lost, $signed(avg), cnt);
    end
  endtask

  task automatic test_acquire_lock();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      send(99, 5, (i == 7) ? 2'd2 : 2'd1, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (st !== e.st || locked !== (e.st == 2'd2) || lost !== e.lost || avg !== e.avg || cnt !== e.cnt) begin
        errors++;
        $display("FAIL acquire[%0d]: got st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want st=%0d lost=%0b avg=%0d cnt=%0d",
                 i, st, locked, lost, $signed(avg), cnt, e.st, e.lost, $signed(e.avg), e.cnt);
      end
    end
  endtask

  task automatic test_hysteresis();
    exp_t       e;
    int         vals [2] = '{40, 51};
    logic [1:0] sts  [2] = '{2'd2, 2'd0};
    logic       lsts [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      send(9, vals[i], sts[i], lsts[i]);
      e = sbq.pop_front();
      checks++;
      if (st !== e.st || locked !== (e.st == 2'd2) || lost !== e.lost || avg !== e.avg || cnt !== e.cnt) begin
        errors++;
        $display("FAIL hysteresis[%0d]: got st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want st=%0d lost=%0b avg=%0d cnt=%0d",
                 i, st, locked, lost, $signed(avg), cnt, e.st, e.lost, $signed(e.avg), e.cnt);
      end
    end
    @(negedge clk);
    checks++;
    if (lost !== 1'b0 || st !== 2'd0) begin
      errors++;
      $display("FAIL hysteresis_pulse_end: lost=%0b st=%0d, want lost=0 st=0", lost, st);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(0, 0, (i == 7) ? 2'd2 : 2'd1, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (st !== e.st || locked !== (e.st == 2'd2) || lost !== e.lost || avg !== e.avg || cnt !== e.cnt) begin
        errors++;
        $display("FAIL timeout_lock[%0d]: got st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want st=%0d lost=%0b avg=%0d cnt=%0d",
                 i, st, locked, lost, $signed(avg), cnt, e.st, e.lost, $signed(e.avg), e.cnt);
      end
    end
    repeat (TMO - 1) @(negedge clk);
    checks++;
    if (st !== 2'd2 || lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_before: st=%0d lost=%0b, want st=2 lost=0", st, lost);
    end
    @(negedge clk);
    checks++;
    if (st !== 2'd3 || locked !== 1'b0 || lost !== 1'b1) begin
      errors++;
      $display("FAIL timeout_stale: st=%0d locked=%0b lost=%0b, want st=3 locked=0 lost=1", st, locked, lost);
    end
    @(negedge clk);
    checks++;
    if (st !== 2'd3 || lost !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse_end: st=%0d lost=%0b, want st=3 lost=0", st, lost);
    end
    send(20, 0, 2'd0, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (st !== e.st || locked !== 1'b0 || lost !== e.lost || avg !== e.avg || cnt !== e.cnt) begin
      errors++;
      $display("FAIL stale_exit: got st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want st=%0d lost=%0b avg=%0d cnt=%0d",
               st, locked, lost, $signed(avg), cnt, e.st, e.lost, $signed(e.avg), e.cnt);
    end
  endtask

  task automatic test_avg_rounding();
    exp_t e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(2, (i == 7) ? -2 : -1, (i == 7) ? 2'd2 : 2'd1, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (st !== e.st || locked !== (e.st == 2'd2) || lost !== e.lost || avg !== e.avg || cnt !== e.cnt) begin
        errors++;
        $display("FAIL rounding[%0d]: got st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want st=%0d lost=%0b avg=%0d cnt=%0d",
                 i, st, locked, lost, $signed(avg), cnt, e.st, e.lost, $signed(e.avg), e.cnt);
      end
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(2, -8388608, 2'd0, 1'b0);
      e = sbq.pop_front();
      checks++;
      if (st !== e.st || locked !== 1'b0 || lost !== e.lost || avg !== e.avg || cnt !== e.cnt) begin
        errors++;
        $display("FAIL full_scale[%0d]: got st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want st=%0d lost=%0b avg=%0d cnt=%0d",
                 i, st, locked, lost, $signed(avg), cnt, e.st, e.lost, $signed(e.avg), e.cnt);
      end
    end
  endtask

  task automatic test_acq_abort();
    exp_t       e;
    int         vals [12] = '{5, 5, 5, 21, 3, 3, 3, 3, 3, 3, 3, 3};
    logic [1:0] sts  [12] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1,
                              2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send(3, vals[i], sts[i], 1'b0);
      e = sbq.pop_front();
      checks++;
      if (st !== e.st || locked !== (e.st == 2'd2) || lost !== e.lost || avg !== e.avg || cnt !== e.cnt) begin
        errors++;
        $display("FAIL acq_abort[%0d]: got st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want st=%0d lost=%0b avg=%0d cnt=%0d",
                 i, st, locked, lost, $signed(avg), cnt, e.st, e.lost, $signed(e.avg), e.cnt);
      end
    end
  endtask

  task automatic test_timeout_race();
    exp_t e;
    do_reset();
    for (int i = 0; i < 8; i++) send(0, 0, (i == 7) ? 2'd2 : 2'd1, 1'b0);
    sbq.delete();
    repeat (TMO - 1) @(negedge clk);
    checks++;
    if (st !== 2'd2 || lost !== 1'b0) begin
      errors++;
      $display("FAIL race_before: st=%0d lost=%0b, want st=2 lost=0", st, lost);
    end
    // This strobe lands on the very edge the timer would expire.
    send(0, 7, 2'd2, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (st !== e.st || locked !== 1'b1 || lost !== e.lost || avg !== e.avg || cnt !== e.cnt) begin
      errors++;
      $display("FAIL race_strobe: got st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want st=%0d lost=%0b avg=%0d cnt=%0d",
               st, locked, lost, $signed(avg), cnt, e.st, e.lost, $signed(e.avg), e.cnt);
    end
    @(negedge clk);
    checks++;
    if (st !== 2'd2 || lost !== 1'b0) begin
      errors++;
      $display("FAIL race_after: st=%0d lost=%0b, want st=2 lost=0", st, lost);
    end
    repeat (TMO - 2) @(negedge clk);
    checks++;
    if (st !== 2'd2) begin
      errors++;
      $display("FAIL race_timer_cleared: st=%0d, want st=2", st);
    end
    @(negedge clk);
    checks++;
    if (st !== 2'd3 || lost !== 1'b1) begin
      errors++;
      $display("FAIL race_late_stale: st=%0d lost=%0b, want st=3 lost=1", st, lost);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) send(0, 1, (i == 7) ? 2'd2 : 2'd1, 1'b0);
    sbq.delete();
    checks++;
    if (st !== 2'd2) begin
      errors++;
      $display("FAIL midreset_prelock: st=%0d, want st=2", st);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    fev = 1'b1;
    fe  = 24'd5;
    #1;
    checks++;
    if ({st, locked, lost, avg, cnt} !== 44'd0) begin
      errors++;
      $display("FAIL midreset_async: st=%0d locked=%0b lost=%0b avg=%0d cnt=%0d, want all 0",
               st, locked, lost, $signed(avg), cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (lost !== 1'b0 || cnt !== 16'd0) begin
        errors++;
        $display("FAIL midreset_hold[%0d]: lost=%0b cnt=%0d, want lost=0 cnt=0", i, lost, cnt);
      end
    end
    rst = 1'b0;
    fev = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (st !== 2'd0 || lost !== 1'b0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL midreset_release: st=%0d lost=%0b cnt=%0d, want st=0 lost=0 cnt=0", st, lost, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_acquire_lock();
    test_hysteresis();
    test_timeout();
    test_avg_rounding();
    test_acq_abort();
    test_timeout_race();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
